led_pattern_sequencer: RTL

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

---
 rtl/led_pattern_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Steps an 8-LED display through four patterns. A debounced press of btn
//   advances the mode. A prescaled tick advances the pattern within a mode.
//
// Ports
//   clk    in   1  sole clock, rising edge
//   rst    in   1  synchronous reset, active high
//   btn    in   1  raw asynchronous pushbutton, 1 = pressed
//   pause  in   1  synchronous level, 1 freezes pattern stepping
//   led    out  8  registered LED drive, 1 = lit
//   mode   out  2  registered mode: 0 STATIC, 1 SHIFT, 2 BOUNCE, 3 BLINK
//
// Mode FSM
//   state  | meaning
//   STATIC | led fixed at 8'hBB, ticks ignored
//   SHIFT  | single lit bit rotates left on each tick
//   BOUNCE | single lit bit walks up and down between bit 0 and bit 7
//   BLINK  | all LEDs toggle together on each tick

module led_pattern_sequencer #(
  parameter int TICK_DIV   = 10000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       pause,
  output logic [7:0] led,
  output logic [1:0] mode
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    STATIC = 2'd0,
    SHIFT  = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } state_t;

  state_t          state;
  logic            sync1, sync2;
  logic            deb_level, deb_prev;
  logic [DW-1:0]   deb_cnt;
  logic            step;
  logic [TW-1:0]   tcnt;
  logic            dir_up;
  logic            tick;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Debounce: deb_cnt counts consecutive cycles in which the synchronized
  // level disagrees with deb_level. The level is accepted on the edge that
  // closes the DEB_CYCLES-th disagreeing cycle. step is registered so that
  // it is a clean one-cycle pulse on the press edge only.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= '0;
      step      <= 1'b0;
    end else begin
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_level <= sync2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
      deb_prev <= deb_level;
      step     <= deb_level & ~deb_prev;
    end
  end

  // Tick is suppressed while paused, so the counter simply holds.
  assign tick = (tcnt == TICK_LAST) && !pause;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= STATIC;
      led    <= 8'hBB;
      tcnt   <= '0;
      dir_up <= 1'b1;
    end else if (step) begin
      // A step discards any coincident tick and restarts the prescaler.
      tcnt   <= '0;
      dir_up <= 1'b1;
      case (state)
        STATIC: begin
          state <= SHIFT;
          led   <= 8'h01;
        end
        SHIFT: begin
          state <= BOUNCE;
          led   <= 8'h01;
        end
        BOUNCE: begin
          state <= BLINK;
          led   <= 8'hFF;
        end
        default: begin
          state <= STATIC;
          led   <= 8'hBB;
        end
      endcase
    end else begin
      if (!pause) begin
        tcnt <= (tcnt == TICK_LAST) ? '0 : tcnt + 1'b1;
      end
      if (tick) begin
        case (state)
          STATIC: led <= 8'hBB;
          SHIFT:  led <= {led[6:0], led[7]};
          BOUNCE: begin
            if (dir_up) begin
              if (led[7]) begin
                led    <= 8'h40;
                dir_up <= 1'b0;
              end else begin
                led <= led << 1;
              end
            end else begin
              if (led[0]) begin
                led    <= 8'h02;
                dir_up <= 1'b1;
              end else begin
                led <= led >> 1;
              end
            end
          end
          default: led <= ~led;
        endcase
      end
    end
  end

  assign mode = state;

endmodule
